// File: rtl/rr_tdm_mult_engine.sv
// N-channel time-division multiply engine: round-robin arbiter, per-channel coefficient
// counters, two-stage multiply pipeline and a credit-protected FWFT output FIFO.
module rr_tdm_mult_engine #(
  parameter int                NUM_CH         = 4,
  parameter int                WIDTH_A        = 8,
  parameter int                WIDTH_B        = 8,
  parameter int                OUT_FIFO_DEPTH = 8,
  parameter logic [NUM_CH-1:0] DECR_MASK      = NUM_CH'(4'b1010),
  localparam int               CW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int               AW             = $clog2(OUT_FIFO_DEPTH),
  localparam int               LW             = AW + 1,
  localparam int               PW             = WIDTH_A + WIDTH_B
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      coef_clr,
  input  logic [NUM_CH-1:0]         s_valid,
  output logic [NUM_CH-1:0]         s_ready,
  input  logic [NUM_CH*WIDTH_A-1:0] s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [PW-1:0]             m_data,
  output logic [CW-1:0]             m_chan,
  output logic [LW-1:0]             fifo_lvl
);

  logic                           run_reg;
  logic [CW-1:0]                  ptr_reg;
  logic [CW-1:0]                  ptr_next;
  logic [NUM_CH-1:0]              req_hi;
  logic [CW-1:0]                  idx_hi;
  logic [CW-1:0]                  idx_lo;
  logic [CW-1:0]                  grant_idx;
  logic                           grant_any;
  logic                           credit_ok;
  logic                           xfer;
  logic [LW:0]                    inflight;
  logic [NUM_CH-1:0][WIDTH_A-1:0] data_all;
  logic [NUM_CH-1:0][WIDTH_B-1:0] coef_all;

  logic                           s1_valid_reg;
  logic [WIDTH_A-1:0]             s1_a_reg;
  logic [WIDTH_B-1:0]             s1_b_reg;
  logic [CW-1:0]                  s1_chan_reg;
  logic                           s2_valid_reg;
  logic [PW-1:0]                  s2_prod_reg;
  logic [CW-1:0]                  s2_chan_reg;

  logic [PW+CW-1:0]               fifo_mem [OUT_FIFO_DEPTH];
  logic [AW-1:0]                  wr_ptr_reg;
  logic [AW-1:0]                  rd_ptr_reg;
  logic [LW-1:0]                  fifo_cnt_reg;
  logic [PW+CW-1:0]               fifo_head;
  logic                           push;
  logic                           pop;

  // Per-channel slices, requests at/above the pointer, grant decode and coefficient counters.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [WIDTH_B-1:0] COEF_INIT = DECR_MASK[gi] ? {WIDTH_B{1'b1}} : '0;
    logic [WIDTH_B-1:0] coef_reg;

    assign data_all[gi] = s_data[gi*WIDTH_A +: WIDTH_A];
    assign req_hi[gi]   = s_valid[gi] && (CW'(gi) >= ptr_reg);
    assign s_ready[gi]  = xfer && (grant_idx == CW'(gi));
    assign coef_all[gi] = coef_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        coef_reg <= COEF_INIT;
      end else if (coef_clr) begin
        coef_reg <= COEF_INIT;
      end else if (s_ready[gi]) begin
        coef_reg <= DECR_MASK[gi] ? coef_reg - 1'b1 : coef_reg + 1'b1;
      end
    end
  end

  // Two-level priority: lowest requester at/above ptr, otherwise lowest requester overall.
  always_comb begin
    idx_hi = '0;
    idx_lo = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_hi[i]) idx_hi = CW'(i);
      if (s_valid[i]) idx_lo = CW'(i);
    end
    grant_idx = (|req_hi) ? idx_hi : idx_lo;
    grant_any = |s_valid;
  end

  // Every accepted sample already owns a FIFO slot, so a pop in this cycle is not needed.
  assign inflight  = (LW+1)'(s1_valid_reg) + (LW+1)'(s2_valid_reg) + (LW+1)'(fifo_cnt_reg);
  assign credit_ok = inflight < (LW+1)'(OUT_FIFO_DEPTH);
  assign xfer      = run_reg && grant_any && credit_ok;

  always_comb begin
    ptr_next = ptr_reg;
    if (xfer) begin
      ptr_next = (grant_idx == CW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // run_reg keeps s_ready low while reset is asserted, without a combinational path from rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_reg <= 1'b0;
      ptr_reg <= '0;
    end else begin
      run_reg <= 1'b1;
      ptr_reg <= ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_chan_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_prod_reg  <= '0;
      s2_chan_reg  <= '0;
    end else begin
      s1_valid_reg <= xfer;
      if (xfer) begin
        s1_a_reg    <= data_all[grant_idx];
        s1_b_reg    <= coef_all[grant_idx];
        s1_chan_reg <= grant_idx;
      end
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_prod_reg <= PW'(s1_a_reg) * PW'(s1_b_reg);
        s2_chan_reg <= s1_chan_reg;
      end
    end
  end

  assign push = s2_valid_reg;
  assign pop  = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {s2_chan_reg, s2_prod_reg};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // Fall-through head read; outputs are forced to zero whenever the FIFO is empty.
  assign fifo_head = fifo_mem[rd_ptr_reg];
  assign m_valid   = (fifo_cnt_reg != '0);
  assign m_data    = m_valid ? fifo_head[PW-1:0] : '0;
  assign m_chan    = m_valid ? fifo_head[PW+CW-1:PW] : '0;
  assign fifo_lvl  = fifo_cnt_reg;

endmodule

// File: tb/tb_rr_tdm_mult_engine.sv
// Directed bench for rr_tdm_mult_engine: arbitration order, latency, credit backpressure,
// coefficient wrap, coef_clr priority and asynchronous reset.
module tb_rr_tdm_mult_engine;

  localparam logic [3:0] DECR = 4'b1010;

  logic        clk = 1'b0;
  logic        rst;
  logic        coef_clr;
  logic [3:0]  s_valid;
  logic [3:0]  s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [1:0]  m_chan;
  logic [3:0]  fifo_lvl;

  int errors = 0;
  int checks = 0;
  int tick_no = 0;
  int acc_ch[$];
  int acc_tick[$];
  int pop_ch[$];
  int pop_data[$];
  int pop_tick[$];
  int exp_ch[$];
  int exp_data[$];
  int coef_m[4];

  rr_tdm_mult_engine dut (
    .clk      (clk),
    .rst      (rst),
    .coef_clr (coef_clr),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_chan   (m_chan),
    .fifo_lvl (fifo_lvl)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) coef_m[i] = DECR[i] ? 255 : 0;
  endfunction

  function automatic void clear_logs();
    acc_ch.delete(); acc_tick.delete();
    pop_ch.delete(); pop_data.delete(); pop_tick.delete();
    exp_ch.delete(); exp_data.delete();
  endfunction

  // Called at a falling edge with inputs set: sample, log, then advance one clock.
  task automatic tick();
    int g;
    #1;
    if (|s_ready) begin
      g = 0;
      for (int i = 0; i < 4; i++) if (s_ready[i]) g = i;
      acc_ch.push_back(g);
      acc_tick.push_back(tick_no);
      exp_ch.push_back(g);
      exp_data.push_back(int'(s_data[g*8 +: 8]) * coef_m[g]);
      if (coef_clr) model_reset();
      else coef_m[g] = DECR[g] ? (coef_m[g] + 255) % 256 : (coef_m[g] + 1) % 256;
    end else if (coef_clr) begin
      model_reset();
    end
    if (m_valid && m_ready) begin
      pop_ch.push_back(int'(m_chan));
      pop_data.push_back(int'(m_data));
      pop_tick.push_back(tick_no);
      $display("t=%0d pop chan=%0d data=%0d lvl=%0d", tick_no, m_chan, m_data, fifo_lvl);
    end
    tick_no++;
    @(negedge clk);
  endtask

  task automatic drain(output bit ok);
    s_valid = 4'h0;
    coef_clr = 1'b0;
    m_ready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (n >= 4 && !m_valid && fifo_lvl == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    s_valid = 4'h0;
    coef_clr = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    model_reset();
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    coef_clr = 1'b0;
    s_valid = 4'hF;
    s_data = {8'd3, 8'd3, 8'd3, 8'd3};
    m_ready = 1'b1;
    repeat (3) tick();
    checks++; if (s_ready !== 4'h0) begin errors++; $display("FAIL reset_s_ready: got %h want 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 16'd0) begin errors++; $display("FAIL reset_m_data: got %0d want 0", m_data); end
    checks++; if (m_chan !== 2'd0) begin errors++; $display("FAIL reset_m_chan: got %0d want 0", m_chan); end
    checks++; if (fifo_lvl !== 4'd0) begin errors++; $display("FAIL reset_fifo_lvl: got %0d want 0", fifo_lvl); end
    model_reset();
    clear_logs();
  endtask

  task automatic test_startup();
    int want_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int want_c[6] = '{0, 1, 2, 3, 0, 1};
    int want_d[6] = '{0, 765, 0, 765, 3, 762};
    bit ok;
    rst = 1'b1;
    repeat (14) tick();
    checks++;
    if (acc_ch.size() < 8) begin errors++; $display("FAIL startup_accepts: got %0d want >=8", acc_ch.size()); end
    else for (int k = 0; k < 8; k++) begin
      checks++;
      if (acc_ch[k] != want_g[k] || acc_tick[k] != acc_tick[0] + k) begin
        errors++; $display("FAIL startup_grant[%0d]: got ch%0d@%0d want ch%0d@%0d", k, acc_ch[k], acc_tick[k], want_g[k], acc_tick[0] + k);
      end
    end
    checks++;
    if (pop_ch.size() < 6) begin errors++; $display("FAIL startup_pops: got %0d want >=6", pop_ch.size()); end
    else begin
      checks++;
      if (pop_tick[0] - acc_tick[0] != 3) begin errors++; $display("FAIL startup_latency: got %0d want 3", pop_tick[0] - acc_tick[0]); end
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (pop_ch[k] != want_c[k] || pop_data[k] != want_d[k]) begin
          errors++; $display("FAIL startup_out[%0d]: got (%0d,%0d) want (%0d,%0d)", k, pop_ch[k], pop_data[k], want_c[k], want_d[k]);
        end
      end
    end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL startup_drain: got not-empty want empty"); end
  endtask

  task automatic test_skip_idle();
    bit ok;
    clear_logs();
    s_valid = 4'b1010;
    repeat (8) tick();
    checks++;
    if (acc_ch.size() != 8) begin errors++; $display("FAIL skip_accepts: got %0d want 8", acc_ch.size()); end
    else for (int k = 0; k < 8; k++) begin
      checks++;
      if (acc_ch[k] != ((k % 2 == 0) ? 1 : 3)) begin errors++; $display("FAIL skip_grant[%0d]: got %0d want %0d", k, acc_ch[k], (k % 2 == 0) ? 1 : 3); end
    end
    drain(ok);
    checks++;
    if (!ok || pop_ch.size() != 8) begin errors++; $display("FAIL skip_pops: got %0d want 8", pop_ch.size()); end
    else for (int k = 0; k < 8; k++) begin
      checks++;
      if (pop_ch[k] != exp_ch[k] || pop_data[k] != exp_data[k]) begin
        errors++; $display("FAIL skip_out[%0d]: got (%0d,%0d) want (%0d,%0d)", k, pop_ch[k], pop_data[k], exp_ch[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int want_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    bit ok;
    clear_logs();
    s_data = {8'd13, 8'd12, 8'd11, 8'd10};
    s_valid = 4'hF;
    m_ready = 1'b0;
    repeat (16) tick();
    checks++; if (acc_ch.size() != 8) begin errors++; $display("FAIL bp_accepts: got %0d want 8", acc_ch.size()); end
    checks++; if (s_ready !== 4'h0) begin errors++; $display("FAIL bp_s_ready: got %h want 0", s_ready); end
    checks++; if (fifo_lvl !== 4'd8) begin errors++; $display("FAIL bp_fifo_lvl: got %0d want 8", fifo_lvl); end
    for (int k = 0; k < 8 && k < acc_ch.size(); k++) begin
      checks++;
      if (acc_ch[k] != want_g[k]) begin errors++; $display("FAIL bp_grant[%0d]: got %0d want %0d", k, acc_ch[k], want_g[k]); end
    end
    m_ready = 1'b1;
    repeat (16) tick();
    drain(ok);
    checks++;
    if (!ok || pop_ch.size() != acc_ch.size() || pop_ch.size() < 16) begin
      errors++; $display("FAIL bp_count: got pops=%0d accepts=%0d want equal and >=16", pop_ch.size(), acc_ch.size());
    end else for (int k = 0; k < pop_ch.size(); k++) begin
      checks++;
      if (pop_ch[k] != exp_ch[k] || pop_data[k] != exp_data[k]) begin
        errors++; $display("FAIL bp_out[%0d]: got (%0d,%0d) want (%0d,%0d)", k, pop_ch[k], pop_data[k], exp_ch[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    for (int ch = 0; ch < 2; ch++) begin
      do_reset();
      s_data = {8'd1, 8'd1, 8'd1, 8'd1};
      s_valid = (ch == 0) ? 4'b0001 : 4'b0010;
      repeat (257) tick();
      drain(ok);
      checks++;
      if (!ok || acc_ch.size() != 257 || pop_data.size() != 257) begin
        errors++; $display("FAIL wrap%0d_count: got acc=%0d pops=%0d want 257", ch, acc_ch.size(), pop_data.size());
      end else for (int k = 0; k < 257; k++) begin
        checks++;
        if (pop_data[k] != ((ch == 0) ? (k % 256) : ((511 - k) % 256)) || pop_ch[k] != ch) begin
          errors++; $display("FAIL wrap%0d_out[%0d]: got (%0d,%0d) want (%0d,%0d)", ch, k, pop_ch[k], pop_data[k], ch, (ch == 0) ? (k % 256) : ((511 - k) % 256));
        end
      end
    end
  endtask

  task automatic test_coef_clr();
    int want_d[7] = '{0, 2, 4, 6, 8, 10, 0};
    bit ok;
    do_reset();
    s_data = {8'd0, 8'd0, 8'd0, 8'd2};
    s_valid = 4'b0001;
    repeat (5) tick();
    coef_clr = 1'b1;
    tick();
    coef_clr = 1'b0;
    tick();
    drain(ok);
    checks++;
    if (!ok || pop_data.size() != 7) begin errors++; $display("FAIL clr_count: got %0d want 7", pop_data.size()); end
    else for (int k = 0; k < 7; k++) begin
      checks++;
      if (pop_data[k] != want_d[k]) begin errors++; $display("FAIL clr_out[%0d]: got %0d want %0d", k, pop_data[k], want_d[k]); end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    clear_logs();
    s_data = {8'd3, 8'd3, 8'd3, 8'd3};
    s_valid = 4'hF;
    m_ready = 1'b0;
    repeat (16) tick();
    checks++; if (fifo_lvl !== 4'd8) begin errors++; $display("FAIL ar_full: got %0d want 8", fifo_lvl); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ar_m_valid: got %b want 0", m_valid); end
    checks++; if (s_ready !== 4'h0) begin errors++; $display("FAIL ar_s_ready: got %h want 0", s_ready); end
    checks++; if (fifo_lvl !== 4'd0) begin errors++; $display("FAIL ar_fifo_lvl: got %0d want 0", fifo_lvl); end
    @(negedge clk);
    s_valid = 4'h0;
    repeat (2) tick();
    rst = 1'b1;
    m_ready = 1'b1;
    model_reset();
    clear_logs();
    repeat (10) tick();
    checks++; if (pop_ch.size() != 0 || m_valid !== 1'b0) begin errors++; $display("FAIL ar_stale: got pops=%0d m_valid=%b want 0", pop_ch.size(), m_valid); end
    s_valid = 4'b0011;
    repeat (2) tick();
    drain(ok);
    checks++;
    if (!ok || pop_ch.size() != 2) begin errors++; $display("FAIL ar_count: got %0d want 2", pop_ch.size()); end
    else begin
      checks++; if (pop_ch[0] != 0 || pop_data[0] != 0) begin errors++; $display("FAIL ar_out0: got (%0d,%0d) want (0,0)", pop_ch[0], pop_data[0]); end
      checks++; if (pop_ch[1] != 1 || pop_data[1] != 765) begin errors++; $display("FAIL ar_out1: got (%0d,%0d) want (1,765)", pop_ch[1], pop_data[1]); end
    end
  endtask

  initial begin
    rst = 1'b0;
    coef_clr = 1'b0;
    s_valid = 4'h0;
    s_data = '0;
    m_ready = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_startup();
    test_skip_idle();
    test_backpressure();
    test_wrap();
    test_coef_clr();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
